en_clk_multi: RTL

//   Multi-channel, run-time programmable clock-enable strobe generator.

---
 rtl/en_clk_multi.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/en_clk_multi.sv
// en_clk_multi
//   Multi-channel, run-time programmable clock-enable strobe generator.
//   Each channel emits a one-cycle tick every Peff clk cycles while running,
//   either periodically or once (one-shot), where Peff = (period == 0) ? 1 : period.
//   All strobes are synchronous to clk.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   en           per-channel run enable (level)
//   sync         one-cycle pulse, restarts the count of every running channel
//   cfg_we       configuration write strobe
//   cfg_ch       channel index for the configuration write
//   cfg_period   new period in clk cycles
//   cfg_oneshot  new mode (0 periodic, 1 one-shot)
//   tick         registered one-cycle strobes, one per channel
//   active       high while the channel is in RUN (taken straight from the state register)
module en_clk_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = 100000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DEFAULT_DIV);

  // Last count value of a period; a zero period behaves as a period of one.
  function automatic logic [CNT_W-1:0] term_count(input logic [CNT_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [NUM_CH-1:0] oneshot_q;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;

  // Configuration registers. Only an index that matches an existing channel
  // selects a target, so out-of-range writes fall through untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]  <= DEF_PERIOD;
        oneshot_q[i] <= 1'b0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(cfg_ch) == i) begin
          period_q[i]  <= cfg_period;
          oneshot_q[i] <= cfg_oneshot;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      tick_q <= tick_d;
    end
  end

  // Next-state logic. Priority inside RUN: en low > sync > terminal > increment.
  // The >= compare lets a period shortened below the current count still
  // terminate on the next edge instead of wrapping the counter.
  always_comb begin
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          cnt_d[i] = '0;
          if (en[i]) state_d[i] = S_RUN;
        end
        S_RUN: begin
          if (!en[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (sync) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] >= term_count(period_q[i])) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            if (oneshot_q[i]) state_d[i] = S_DONE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        S_DONE: begin
          cnt_d[i] = '0;
          if (!en[i]) state_d[i] = S_IDLE;
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs come only from registers.
  always_comb begin
    tick = tick_q;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (state_q[i] == S_RUN);
    end
  end

endmodule
